pc_fetch_responder: RTL
=======================

Name: pc_fetch_responder

Overview:
- Responder side of the PC-fetch request interface driven by the front-end PC controller.
- Accepts a 19-bit 8-byte-word index via valid/ready.
- Reads LINE_BEATS consecutive 64-bit words from the DDR read port, one outstanding beat at a time, and assembles them into a 512-bit fetch line for the instruction buffer.
- Signals completion with a one-cycle pc_operation_done pulse. Requests cancelled mid-flight still complete, but their line is discarded.

Parameters:
- LINE_BEATS, 8: 64-bit beats per fetch line. Line width is LINE_BEATS*64.
- IDX_W, 19: width of the word index (pc[21:3]).
- TIMEOUT_CYCLES, 255: watchdog limit per beat. Used only with PC_FETCH_TIMEOUT_EN.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_index_valid  in  1  fetch request valid.
- pc_index  in  IDX_W  start word index.
- pc_index_ready  out  1  request accepted when valid&ready.
- cancel_pc_fetch  in  1  level; discard the in-flight line.
- pc_operation_done  out  1  one-cycle completion pulse.
- fetch_line  out  LINE_BEATS*64  assembled line; beat i in bits [64i+63:64i].
- fetch_line_valid  out  1  one-cycle pulse with done when the line is not cancelled.
- ddr_req_valid  out  1  beat read request.
- ddr_req_addr  out  IDX_W  beat word index.
- ddr_req_ready  in  1  DDR accepts request.
- ddr_rdata_valid  in  1  read data return, one cycle.
- ddr_rdata  in  64  read data.
- fetch_timeout_err  out  1  sticky error flag; present only with PC_FETCH_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, active-high): all outputs 0 except pc_index_ready=1; state IDLE; beat counter, cancel latch and fetch_line cleared. Reset during any state aborts the operation with no done pulse.
- IDLE:
  - pc_index_ready=1.
  - On valid&ready: latch base=pc_index, beat=0, cancel_latch=0, go to REQ.
  - No other request is accepted until the FSM returns to IDLE.
- REQ:
  - ddr_req_valid=1; ddr_req_addr=(base+beat) mod 2^IDX_W, so 0x7FFFF+1 wraps to 0.
  - Request is held stable until ddr_req_ready; go to WAIT.
- WAIT:
  - On ddr_rdata_valid, write ddr_rdata into slot[beat].
  - If beat==LINE_BEATS-1, go to DONE; else beat+1 and go to REQ.
  - ddr_rdata_valid outside WAIT is ignored.
- DONE (one cycle):
  - pc_operation_done=1.
  - fetch_line_valid=1 only if (cancel_latch|cancel_pc_fetch)==0.
  - Go to IDLE; pc_index_ready returns to 1 the following cycle.
- Cancel:
  - cancel_pc_fetch sampled high in any non-IDLE state sets cancel_latch.
  - Remaining beats are still read, because DDR returns cannot be aborted.
  - Done still pulses; fetch_line_valid stays 0.
  - Cancel in IDLE has no effect.
- fetch_line holds its value between operations and changes only on beat writes.
- Minimum latency, accept to done: 2*LINE_BEATS+1 cycles with zero-wait DDR (17 for default).

Optional Feature:
- Macro: PC_FETCH_TIMEOUT_EN.
- Defined:
  - A per-beat counter runs in REQ and WAIT and resets on each beat transition.
  - When it reaches TIMEOUT_CYCLES, the slot is filled with 64'h0, fetch_timeout_err is set (sticky until reset), and the FSM proceeds as if data had arrived.
  - That line's fetch_line_valid is suppressed; done still pulses.
  - A late ddr_rdata_valid is ignored per the WAIT rule.
- Undefined:
  - No counter, no fetch_timeout_err port; the FSM waits indefinitely.

Test Plan:
- Basic line:
  - Stimulus: pc_index=0x00010, DDR returns data=addr each beat, zero wait.
  - Required: addresses 0x10..0x17 issued in order; done and fetch_line_valid pulse together 17 cycles after accept; fetch_line[63:0]=0x10, fetch_line[511:448]=0x17.
- Wrap:
  - Stimulus: pc_index=0x7FFFC.
  - Required: addresses 0x7FFFC,0x7FFFD,0x7FFFE,0x7FFFF,0x0,0x1,0x2,0x3.
- Backpressure:
  - Stimulus: ddr_req_ready low 3 cycles on beat 2, rdata delayed 5 cycles on beat 5.
  - Required: ddr_req_addr stable while stalled; correct line; done at cycle 17+3+5=25.
- Cancel:
  - Stimulus: cancel_pc_fetch pulsed 1 cycle during beat 3.
  - Required: all 8 beats still requested; done=1 with fetch_line_valid=0.
  - Follow-up: next request is accepted the cycle after done+1 and returns a valid line.
- Reset mid-operation:
  - Stimulus: reset asserted in WAIT of beat 4.
  - Required: next cycle pc_index_ready=1, ddr_req_valid=0, no done pulse.
- Timeout (PC_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=10):
  - Stimulus: beat 1 never returns data.
  - Required: fetch_timeout_err=1 after 10 cycles in beat 1; remaining beats complete; done=1, fetch_line_valid=0, slot1=0.

Source files
------------

// File: rtl/pc_fetch_responder.sv
// rtl/pc_fetch_responder.sv - PC-fetch responder assembling DDR read beats into a fetch line
//
// Accepts a word index from the front-end PC controller. Reads LINE_BEATS
// consecutive 64-bit words from the DDR read port, with one beat outstanding at
// a time, and assembles them into one fetch line.
//
// Ports:
//   clock, reset         sole rising-edge clock; synchronous active-high reset
//   pc_index_valid/ready request handshake; pc_index is the start word index
//   cancel_pc_fetch      level; drops the in-flight line, the beats still finish
//   pc_operation_done    one-cycle completion pulse
//   fetch_line(_valid)   assembled line, beat i in [64i+63:64i]; valid pulse
//                        with done when the line was not cancelled
//   ddr_req_*            beat read request (word index), valid/ready
//   ddr_rdata(_valid)    single-cycle read data return
//   fetch_timeout_err    sticky watchdog flag (only with PC_FETCH_TIMEOUT_EN)
//
// Build option: define PC_FETCH_TIMEOUT_EN to add the per-beat watchdog.
module pc_fetch_responder #(
  parameter int LINE_BEATS     = 8,
  parameter int IDX_W          = 19,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pc_index_valid,
  input  logic [IDX_W-1:0]         pc_index,
  output logic                     pc_index_ready,
  input  logic                     cancel_pc_fetch,
  output logic                     pc_operation_done,
  output logic [LINE_BEATS*64-1:0] fetch_line,
  output logic                     fetch_line_valid,
  output logic                     ddr_req_valid,
  output logic [IDX_W-1:0]         ddr_req_addr,
  input  logic                     ddr_req_ready,
  input  logic                     ddr_rdata_valid,
  input  logic [63:0]              ddr_rdata
`ifdef PC_FETCH_TIMEOUT_EN
  ,
  output logic                     fetch_timeout_err
`endif
);

  localparam int                BEAT_W    = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  base;
  logic [BEAT_W-1:0] beat;
  logic              cancel_latch;

  logic              beat_timeout;
  logic              timeout_fire;
  logic              beat_end;
  logic [63:0]       beat_data;

`ifdef PC_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // The counter covers the whole beat (request and wait phases together).
  assign beat_timeout = ((state == S_REQ) || (state == S_WAIT)) &&
                        (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out: this expression is constant false.
  assign beat_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // A beat ends on real data in WAIT, or on watchdog expiry with a zero slot.
  always_comb begin
    beat_end     = 1'b0;
    beat_data    = ddr_rdata;
    timeout_fire = 1'b0;
    if ((state == S_WAIT) && ddr_rdata_valid) begin
      beat_end = 1'b1;
    end else if (beat_timeout) begin
      beat_end     = 1'b1;
      beat_data    = '0;
      timeout_fire = 1'b1;
    end
  end

  // Cancel arriving in the DONE cycle itself must still suppress the line.
  assign fetch_line_valid = pc_operation_done & ~(cancel_latch | cancel_pc_fetch);

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      pc_index_ready    <= 1'b1;
      pc_operation_done <= 1'b0;
      ddr_req_valid     <= 1'b0;
      ddr_req_addr      <= '0;
      base              <= '0;
      beat              <= '0;
      cancel_latch      <= 1'b0;
      fetch_line        <= '0;
`ifdef PC_FETCH_TIMEOUT_EN
      to_cnt            <= '0;
      fetch_timeout_err <= 1'b0;
`endif
    end else begin
      pc_operation_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pc_index_valid) begin
            base           <= pc_index;
            beat           <= '0;
            cancel_latch   <= 1'b0;
            ddr_req_valid  <= 1'b1;
            ddr_req_addr   <= pc_index;
            pc_index_ready <= 1'b0;
            state          <= S_REQ;
          end
        end
        S_REQ: begin
          if (ddr_req_ready) begin
            ddr_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
        end
        S_DONE: begin
          pc_index_ready <= 1'b1;
          state          <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Beat completion overrides the REQ->WAIT move when the watchdog fires in REQ.
      if (beat_end) begin
        fetch_line[64*beat +: 64] <= beat_data;
        if (beat == LAST_BEAT) begin
          ddr_req_valid     <= 1'b0;
          pc_operation_done <= 1'b1;
          state             <= S_DONE;
        end else begin
          beat          <= beat + BEAT_W'(1);
          ddr_req_valid <= 1'b1;
          ddr_req_addr  <= base + IDX_W'(beat) + IDX_W'(1);
          state         <= S_REQ;
        end
      end

      if ((state != S_IDLE) && cancel_pc_fetch) begin
        cancel_latch <= 1'b1;
      end

`ifdef PC_FETCH_TIMEOUT_EN
      if (beat_end || (state == S_IDLE) || (state == S_DONE)) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      // A timed-out line is treated as cancelled so its valid pulse is dropped.
      if (timeout_fire) begin
        fetch_timeout_err <= 1'b1;
        cancel_latch      <= 1'b1;
      end
`endif
    end
  end

endmodule
